set_bit_serializer: RTL and testbench

- Accepts a 32-bit word over a valid/ready handshake and emits the index of every set bit, one per beat, highest bit first.
- Sits directly downstream of the word source and wraps one msb_index instance. msb_index encodes the residual word each cycle. The serializer clears each emitted bit until the word is exhausted.
- Used to turn request/flag vectors into a serial stream of indices for downstream per-index processing.

---
 rtl/set_bit_serializer_pkg.sv | 11 +
 rtl/set_bit_serializer_if.sv | 21 ++
 rtl/set_bit_serializer_msb_index.sv | 13 +
 rtl/set_bit_serializer.sv | 64 ++++++
 tb/tb_set_bit_serializer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/set_bit_serializer_pkg.sv
// Shared constants, FSM state type and bit-clear helper for the set-bit serializer.
package set_bit_serializer_pkg;
  localparam int W  = 32;
  localparam int IW = 5;

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic logic [W-1:0] onehot(input logic [IW-1:0] idx);
    return {{(W-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/set_bit_serializer_if.sv
// Word-in / index-out handshake bundle for the set-bit serializer.
interface set_bit_serializer_if;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [set_bit_serializer_pkg::W-1:0]  in_word;
  logic                                 abort;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [set_bit_serializer_pkg::IW-1:0] out_index;
  logic                                 out_last;
  logic                                 out_empty;

  modport master (
    output in_valid, in_word, abort, out_ready,
    input  in_ready, out_valid, out_index, out_last, out_empty
  );
  modport slave (
    input  in_valid, in_word, abort, out_ready,
    output in_ready, out_valid, out_index, out_last, out_empty
  );
endinterface

// File: rtl/set_bit_serializer_msb_index.sv
// Priority encoder: index of the highest set bit; 0 for an all-zero word.
module msb_index
  import set_bit_serializer_pkg::*;
(
  input  logic [W-1:0]  in,
  output logic [IW-1:0] index
);
  always_comb begin
    index = '0;
    for (int i = 0; i < W; i++)
      if (in[i]) index = IW'(i);
  end
endmodule

// File: rtl/set_bit_serializer.sv
// Serializes the set-bit indices of a 32-bit word, MSB first, one beat per cycle.
module set_bit_serializer
  import set_bit_serializer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  set_bit_serializer_if.slave bus
);
  state_t        state, state_n;
  logic [W-1:0]  res, res_n;
  logic          zf, zf_n;
  logic [IW-1:0] idx;
  logic          last, emit, in_rdy, fire_in;

  msb_index u_msb (.in(res), .index(idx));

  // Reset still pending at this edge suppresses the beat, so nothing is handshaked.
  assign emit    = (state == EMIT) && !rst;
  assign last    = zf || ((res & (res - 32'd1)) == '0);
  assign in_rdy  = !rst && !bus.abort &&
                   ((state == IDLE) || (emit && bus.out_ready && last));
  assign fire_in = bus.in_valid && in_rdy;

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = emit;
  assign bus.out_index = emit ? idx  : '0;
  assign bus.out_last  = emit && last;
  assign bus.out_empty = emit && zf;

  always_comb begin
    state_n = state;
    res_n   = res;
    zf_n    = zf;
    if (bus.abort) begin
      state_n = IDLE;
      res_n   = '0;
      zf_n    = 1'b0;
    end else if (fire_in) begin
      state_n = EMIT;
      res_n   = bus.in_word;
      zf_n    = (bus.in_word == '0);
    end else if (state == EMIT && bus.out_ready) begin
      if (last) begin
        state_n = IDLE;
        res_n   = '0;
        zf_n    = 1'b0;
      end else begin
        res_n = res & ~onehot(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      res   <= '0;
      zf    <= 1'b0;
    end else begin
      state <= state_n;
      res   <= res_n;
      zf    <= zf_n;
    end
  end
endmodule

// File: tb/tb_set_bit_serializer.sv
// Directed bench for set_bit_serializer: table of whole words plus corner sequences.
module tb_set_bit_serializer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  set_bit_serializer_if bus();

  set_bit_serializer dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      word;
    int               n;
    logic [3:0][4:0]  idx;
    logic             empty;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic beat(input string name, input logic [4:0] i, input logic l, input logic e);
    chk({name, " valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, " index"}, 32'(bus.out_index), 32'(i));
    chk({name, " last"},  32'(bus.out_last),  32'(l));
    chk({name, " empty"}, 32'(bus.out_empty), 32'(e));
  endtask

  task automatic accept(input logic [31:0] w);
    bus.in_valid = 1'b1; bus.in_word = w;
    #1 chk("accept ready", 32'(bus.in_ready), 32'd1);
    chk("accept no beat", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'hA0000005, 4, {5'd0, 5'd2, 5'd29, 5'd31}, 1'b0};
    vecs[1] = '{32'h00000000, 1, {5'd0, 5'd0, 5'd0, 5'd0},   1'b1};
    vecs[2] = '{32'h80000000, 1, {5'd0, 5'd0, 5'd0, 5'd31},  1'b0};
    vecs[3] = '{32'h00000001, 1, {5'd0, 5'd0, 5'd0, 5'd0},   1'b0};
    vecs[4] = '{32'h00010001, 2, {5'd0, 5'd0, 5'd0, 5'd16},  1'b0};
    vecs[5] = '{32'h00000003, 2, {5'd0, 5'd0, 5'd0, 5'd1},   1'b0};

    rst = 1'b1; bus.in_valid = 1'b0; bus.in_word = '0; bus.abort = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1 chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("idle in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle index", 32'(bus.out_index), 32'd0);
    @(negedge clk);

    // Table: whole words drained with out_ready held high.
    foreach (vecs[v]) begin
      accept(vecs[v].word);
      for (int b = 0; b < vecs[v].n; b++) begin
        #1 beat($sformatf("vec%0d beat%0d", v, b), vecs[v].idx[b], b == vecs[v].n - 1, vecs[v].empty);
        @(negedge clk);
      end
      #1 chk($sformatf("vec%0d done", v), 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end

    // Reset mid-word: 0xF0F0F0F0 after three beats.
    accept(32'hF0F0F0F0);
    for (int b = 0; b < 3; b++) begin
      #1 beat("pre-rst", 5'(31 - b), 1'b0, 1'b0);
      @(negedge clk);
    end
    rst = 1'b1;
    #1 chk("mid rst valid", 32'(bus.out_valid), 32'd0);
    chk("mid rst ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("post rst valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end

    // Backpressure on the first beat of 0x00010001.
    bus.out_ready = 1'b1;
    accept(32'h00010001);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1 beat("stall", 5'd16, 1'b0, 1'b0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1 beat("bp b0", 5'd16, 1'b0, 1'b0);
    @(negedge clk);
    #1 beat("bp b1", 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    #1 chk("bp done", 32'(bus.out_valid), 32'd0);
    @(negedge clk);

    // Back-to-back: 0x3 then 0x80000000 with in_valid held.
    bus.in_valid = 1'b1; bus.in_word = 32'h3;
    #1 chk("b2b accept", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    #1 beat("b2b b0", 5'd1, 1'b0, 1'b0);
    chk("b2b blocked", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.in_word = 32'h80000000;
    #1 beat("b2b b1", 5'd0, 1'b1, 1'b0);
    chk("b2b ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 beat("b2b b2", 5'd31, 1'b1, 1'b0);
    @(negedge clk);
    #1 chk("b2b done", 32'(bus.out_valid), 32'd0);
    @(negedge clk);

    // All ones: 32 beats, last only on index 0.
    accept(32'hFFFFFFFF);
    for (int b = 0; b < 32; b++) begin
      #1 beat("ones", 5'(31 - b), b == 31, 1'b0);
      @(negedge clk);
    end
    #1 chk("ones done", 32'(bus.out_valid), 32'd0);
    @(negedge clk);

    // Abort on the second beat of 0xFFFFFFFF, then a fresh word.
    accept(32'hFFFFFFFF);
    #1 beat("abort b0", 5'd31, 1'b0, 1'b0);
    @(negedge clk);
    bus.abort = 1'b1; bus.in_valid = 1'b1; bus.in_word = 32'h4;
    #1 beat("abort b1", 5'd30, 1'b0, 1'b0);
    chk("abort ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    #1 chk("abort idle valid", 32'(bus.out_valid), 32'd0);
    chk("abort idle ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    accept(32'h4);
    #1 beat("post abort", 5'd2, 1'b1, 1'b0);
    @(negedge clk);
    #1 chk("post abort done", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
